// File: rtl/draw_scheduler.sv
// Erases the previous ball and paddles, then draws them at their new positions,
// one pixel per accepted handshake, once per frame tick.
module draw_scheduler #(
  parameter int PADDLE_W = 2,
  parameter int PADDLE_H = 20,
  parameter int BALL_SZ = 2,
  parameter logic [2:0] FG_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  input  logic [7:0] p1_x,
  input  logic [6:0] p1_y,
  input  logic [7:0] p2_x,
  input  logic [6:0] p2_y,
  input  logic       plot_ready,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] overrun_cnt
);

  typedef enum logic [2:0] {
    IDLE, ERASE_BALL, ERASE_P1, ERASE_P2,
    DRAW_P1, DRAW_P2, DRAW_BALL, DONE
  } state_t;

  localparam logic [7:0] PW = 8'(PADDLE_W);
  localparam logic [6:0] PH = 7'(PADDLE_H);
  localparam logic [7:0] BW = 8'(BALL_SZ);
  localparam logic [6:0] BH = 7'(BALL_SZ);

  state_t state, state_n;
  logic [7:0] dx;
  logic [6:0] dy;
  logic [7:0] nb_x, np1_x, np2_x, ob_x, op1_x, op2_x;
  logic [6:0] nb_y, np1_y, np2_y, ob_y, op1_y, op2_y;
  logic old_valid;

  logic [7:0] base_x, w, px;
  logic [6:0] base_y, h, py;
  logic active, erase, onscreen, step, last;

  always_comb begin
    base_x = 8'd0;
    base_y = 7'd0;
    w = 8'd1;
    h = 7'd1;
    active = 1'b1;
    erase = 1'b0;
    unique case (state)
      ERASE_BALL: begin
        base_x = ob_x; base_y = ob_y; w = BW; h = BH; erase = 1'b1;
      end
      ERASE_P1: begin
        base_x = op1_x; base_y = op1_y; w = PW; h = PH; erase = 1'b1;
      end
      ERASE_P2: begin
        base_x = op2_x; base_y = op2_y; w = PW; h = PH; erase = 1'b1;
      end
      DRAW_P1: begin
        base_x = np1_x; base_y = np1_y; w = PW; h = PH;
      end
      DRAW_P2: begin
        base_x = np2_x; base_y = np2_y; w = PW; h = PH;
      end
      DRAW_BALL: begin
        base_x = nb_x; base_y = nb_y; w = BW; h = BH;
      end
      default: active = 1'b0;
    endcase
  end

  assign px = base_x + dx;
  assign py = base_y + dy;
  assign onscreen = (px <= 8'd159) && (py <= 7'd119);
  // Off-screen pixels are skipped in one cycle without a handshake.
  assign step = active && (!onscreen || plot_ready);
  assign last = (dx == w - 8'd1) && (dy == h - 7'd1);

  assign vga_plot = active && onscreen;
  assign vga_x = active ? px : 8'd0;
  assign vga_y = active ? py : 7'd0;
  assign vga_colour = (active && !erase) ? FG_COLOUR : BG_COLOUR;
  assign busy = (state != IDLE);
  assign frame_done = (state == DONE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (frame_tick) state_n = old_valid ? ERASE_BALL : DRAW_P1;
      ERASE_BALL: if (step && last) state_n = ERASE_P1;
      ERASE_P1: if (step && last) state_n = ERASE_P2;
      ERASE_P2: if (step && last) state_n = DRAW_P1;
      DRAW_P1: if (step && last) state_n = DRAW_P2;
      DRAW_P2: if (step && last) state_n = DRAW_BALL;
      DRAW_BALL: if (step && last) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dx <= 8'd0;
      dy <= 7'd0;
      old_valid <= 1'b0;
      overrun_cnt <= 8'd0;
      nb_x <= 8'd0; nb_y <= 7'd0;
      np1_x <= 8'd0; np1_y <= 7'd0;
      np2_x <= 8'd0; np2_y <= 7'd0;
      ob_x <= 8'd0; ob_y <= 7'd0;
      op1_x <= 8'd0; op1_y <= 7'd0;
      op2_x <= 8'd0; op2_y <= 7'd0;
    end else begin
      state <= state_n;
      if (step) begin
        if (last) begin
          dx <= 8'd0;
          dy <= 7'd0;
        end else if (dx == w - 8'd1) begin
          dx <= 8'd0;
          dy <= dy + 7'd1;
        end else begin
          dx <= dx + 8'd1;
        end
      end
      if (frame_tick && state == IDLE) begin
        nb_x <= ball_x; nb_y <= ball_y;
        np1_x <= p1_x; np1_y <= p1_y;
        np2_x <= p2_x; np2_y <= p2_y;
      end
      if (frame_tick && state != IDLE && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;
      if (state == DONE) begin
        ob_x <= nb_x; ob_y <= nb_y;
        op1_x <= np1_x; op1_y <= np1_y;
        op2_x <= np2_x; op2_y <= np2_y;
        old_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: expected pixels are queued per frame
// and a negedge monitor pops one on every accepted plot.
module tb_draw_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  logic [7:0] ball_x, p1_x, p2_x;
  logic [6:0] ball_y, p1_y, p2_y;
  logic plot_ready = 1'b1;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic vga_plot, busy, frame_done;
  logic [7:0] overrun_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [17:0] sb[$];

  logic ovalid = 1'b0;
  logic [7:0] ob_x, op1_x, op2_x;
  logic [6:0] ob_y, op1_y, op2_y;

  draw_scheduler dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .ball_x(ball_x), .ball_y(ball_y),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .plot_ready(plot_ready),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .frame_done(frame_done),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  logic hold_prev = 1'b0;
  logic [17:0] prev_pix;

  always @(negedge clk) begin
    logic [17:0] e;
    if (hold_prev && vga_plot) begin
      vectors++;
      if ({vga_x, vga_y, vga_colour} !== prev_pix) begin
        miscompares++;
        $display("FAIL hold: got %h want %h", {vga_x, vga_y, vga_colour}, prev_pix);
      end
    end
    hold_prev = vga_plot && !plot_ready && !reset;
    prev_pix = {vga_x, vga_y, vga_colour};
    if (vga_plot && plot_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL extra_plot: got (%0d,%0d,%b) want none", vga_x, vga_y, vga_colour);
      end else begin
        e = sb.pop_front();
        if ({vga_x, vga_y, vga_colour} !== e) begin
          miscompares++;
          $display("FAIL pixel: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                   vga_x, vga_y, vga_colour, e[17:10], e[9:3], e[2:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push_rect(input logic [7:0] x, input logic [6:0] y,
                           input int w, input int h, input logic [2:0] c);
    logic [7:0] px;
    logic [6:0] py;
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++) begin
        px = x + 8'(i);
        py = y + 7'(j);
        if (px <= 8'd159 && py <= 7'd119) sb.push_back({px, py, c});
      end
  endtask

  task automatic push_frame();
    if (ovalid) begin
      push_rect(ob_x, ob_y, 2, 2, 3'b000);
      push_rect(op1_x, op1_y, 2, 20, 3'b000);
      push_rect(op2_x, op2_y, 2, 20, 3'b000);
    end
    push_rect(p1_x, p1_y, 2, 20, 3'b111);
    push_rect(p2_x, p2_y, 2, 20, 3'b111);
    push_rect(ball_x, ball_y, 2, 2, 3'b111);
    ob_x = ball_x; ob_y = ball_y;
    op1_x = p1_x; op1_y = p1_y;
    op2_x = p2_x; op2_y = p2_y;
    ovalid = 1'b1;
  endtask

  // tick_mode 1: three ticks while busy; 2: ticks on cycles 1..300
  task automatic run_frame(input string name, input int exp_lat, input bit bp,
                           input int tick_mode, input int rst_at);
    int n;
    bit done;
    push_frame();
    @(posedge clk); #1;
    frame_tick = 1'b1;
    plot_ready = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 2000) begin
      @(posedge clk); #1;
      n++;
      frame_tick = (tick_mode == 1 && (n == 10 || n == 20 || n == 30)) ||
                   (tick_mode == 2 && n <= 300);
      plot_ready = bp ? n[0] : 1'b1;
      reset = (rst_at != 0 && n == rst_at);
      @(negedge clk);
      if (rst_at != 0 && n == rst_at + 1) begin
        chk({name, "_plot"}, vga_plot, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_ovr"}, overrun_cnt, 0);
        done = 1'b1;
      end else if (frame_done) begin
        done = 1'b1;
      end
    end
    chk({name, "_latency"}, n, exp_lat);
    @(posedge clk); #1;
    frame_tick = 1'b0;
    reset = 1'b0;
    plot_ready = 1'b1;
    if (rst_at != 0) begin
      sb.delete();
      ovalid = 1'b0;
    end else begin
      chk({name, "_left"}, sb.size(), 0);
    end
  endtask

  initial begin
    ball_x = 8'd80; ball_y = 7'd75;
    p1_x = 8'd10; p1_y = 7'd50;
    p2_x = 8'd148; p2_y = 7'd50;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_plot", vga_plot, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_x", vga_x, 0);
    chk("rst_y", vga_y, 0);
    chk("rst_col", vga_colour, 0);
    chk("rst_ovr", overrun_cnt, 0);

    run_frame("first", 85, 1'b0, 0, 0);
    ball_x = 8'd81; ball_y = 7'd76;
    run_frame("second", 169, 1'b0, 0, 0);
    run_frame("bp", 336, 1'b1, 0, 0);
    run_frame("ovr3", 169, 1'b0, 1, 0);
    chk("ovr3_cnt", overrun_cnt, 3);
    run_frame("ovr300", 336, 1'b1, 2, 0);
    chk("ovr300_cnt", overrun_cnt, 255);
    ball_x = 8'd159; ball_y = 7'd119;
    run_frame("clip", 169, 1'b0, 0, 0);
    ball_x = 8'd80; ball_y = 7'd75;
    run_frame("midrst", 141, 1'b0, 0, 140);

    @(posedge clk); #1;
    reset = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    frame_tick = 1'b0;
    @(negedge clk);
    chk("rst_tick_busy", busy, 0);
    chk("rst_tick_plot", vga_plot, 0);

    run_frame("refirst", 85, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 SHALL have parameter PADDLE_W, default 2, paddle width in pixels.
REQ-002 SHALL have parameter PADDLE_H, default 20, paddle height in pixels.
REQ-003 SHALL have parameter BALL_SZ, default 2, ball edge length in pixels (square).
REQ-004 SHALL have parameter FG_COLOUR, default 3'b111, paddle and ball colour.
REQ-005 SHALL have parameter BG_COLOUR, default 3'b000, erase colour.
REQ-006 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port frame_tick  in  1  one-cycle frame-start pulse (60 Hz, clk domain).
REQ-009 SHALL have ports ball_x / ball_y  in  8 / 7  ball top-left position.
REQ-010 SHALL have ports p1_x / p1_y, p2_x / p2_y  in  8 / 7 each  paddle top-left positions.
REQ-011 SHALL have port plot_ready  in  1  pixel-writer accepts a pixel this cycle.
REQ-012 SHALL have ports vga_x / vga_y / vga_colour  out  8 / 7 / 3  pixel address and colour.
REQ-013 SHALL have port vga_plot  out  1  pixel valid.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.
REQ-015 SHALL have port frame_done  out  1  one-cycle pulse on frame completion.
REQ-016 SHALL have port overrun_cnt  out  8  saturating count of frame_tick pulses dropped while busy.

Function
REQ-017 SHALL implement states IDLE, ERASE_BALL, ERASE_P1, ERASE_P2, DRAW_P1, DRAW_P2, DRAW_BALL, DONE, visited in that order.
REQ-018 SHALL, on frame_tick in IDLE, snapshot all five positions into "new" registers and enter ERASE_BALL, or DRAW_P1 if old_valid=0.
REQ-019 SHALL drive each rectangle as a raster: column offset dx fastest (0..W-1), then row offset dy (0..H-1); pixel = (base_x+dx, base_y+dy), 8/7-bit truncating add.
REQ-020 SHALL use "old" registers with BG_COLOUR in ERASE_* states, and "new" registers with FG_COLOUR in DRAW_* states.
REQ-021 SHALL, as handshake: vga_plot high with vga_x/vga_y/vga_colour stable until a cycle with vga_plot and plot_ready both high; counters advance only on that cycle.
REQ-022 SHALL, for an out-of-screen pixel (x>159 or y>119), hold vga_plot low and advance one pixel in one cycle regardless of plot_ready.
REQ-023 SHALL, after the last pixel of a rectangle, enter the next state with dx=dy=0 on the following cycle; no idle cycle between rectangles.
REQ-024 SHALL, in DONE, pulse frame_done for one cycle, copy new to old, set old_valid=1, and return to IDLE.
REQ-025 SHALL, on frame_tick in any state other than IDLE, ignore the tick (no snapshot) and increment overrun_cnt, saturating at 255.
REQ-026 SHALL meet latency with plot_ready tied high: tick at cycle T -> plots at T+1..T+168 (T+1..T+84 if old_valid=0) and frame_done at T+169 (T+85).
REQ-027 SHALL keep vga_plot low in IDLE and DONE.

Reset
REQ-028 SHALL, on reset (including mid-frame), in the next cycle: state=IDLE, vga_plot=0, frame_done=0, busy=0, vga_x=0, vga_y=0, vga_colour=BG_COLOUR, overrun_cnt=0, old_valid=0, dx=dy=0.
REQ-029 SHALL, when reset and frame_tick coincide, give reset priority and discard the tick.

Verification
REQ-030 SHALL test first frame: reset, ready=1, ball (80,75), p1 (10,50), p2 (148,50), tick -> 84 plots, first (10,50,111), 40th (11,69), 81st (80,75), frame_done at T+85.
REQ-031 SHALL test second frame: ball moved to (81,76), tick -> 168 plots, first four BG at (80,75),(81,75),(80,76),(81,76), last FG at (82,77), frame_done at T+169.
REQ-032 SHALL test backpressure: plot_ready toggled 1-0-1-0 -> each pixel held until accepted, no duplicate or skipped pixel, frame_done at T+336.
REQ-033 SHALL test overrun: three ticks while busy -> overrun_cnt=3, frame pixel sequence unchanged; 300 dropped ticks -> overrun_cnt=255.
REQ-034 SHALL test clipping: ball (159,119) -> only (159,119) plotted for the ball; the 3 clipped pixels produce no vga_plot.
REQ-035 SHALL test mid-frame reset: reset during DRAW_P2 -> next cycle vga_plot=0, busy=0; next tick performs first-frame sequence (84 plots).
